// File: rtl/bcd_time_pkg.sv
// Shared constants, time-record type and BCD helpers for the time-of-day counter.
package bcd_time_pkg;

  localparam logic [3:0] BCD_UNITS_MAX   = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX    = 4'd5;
  localparam logic [3:0] HOUR_TENS_MAX   = 4'd2;
  localparam logic [3:0] HOUR_UNITS_WRAP = 4'd3;
  localparam logic [3:0] DIGIT_ZERO      = 4'h0;
  localparam logic [7:0] TIME_RESET      = 8'h00;
  localparam logic [7:0] HOUR_MAX        = 8'h23;
  localparam logic [7:0] MINSEC_MAX      = 8'h59;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } bcd_time_t;

  // Both digits must be decimal; for valid BCD a plain numeric compare orders correctly.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= BCD_UNITS_MAX) && (v[3:0] <= BCD_UNITS_MAX) && (v <= max);
  endfunction

  // 24h BCD hour to {pm, 12h BCD hour}; 13..23 subtract 12 with a BCD borrow.
  function automatic logic [8:0] h24_to_h12(input logic [7:0] h24);
    logic [3:0] t;
    logic [3:0] u;
    logic       pm;
    logic [7:0] h;
    t = h24[7:4];
    u = h24[3:0];
    if (h24 == 8'h00) begin
      pm = 1'b0;
      h  = 8'h12;
    end else if (h24 < 8'h12) begin
      pm = 1'b0;
      h  = h24;
    end else if (h24 == 8'h12) begin
      pm = 1'b1;
      h  = 8'h12;
    end else begin
      pm = 1'b1;
      if (u >= 4'd2) h = {t - 4'd1, u - 4'd2};
      else           h = {t - 4'd2, u + 4'd8};
    end
    return {pm, h};
  endfunction

endpackage

// File: rtl/bcd_digit_ctr.sv
// Single BCD digit: synchronous load, count enable, static terminal count MAX
// plus a wrap_i input that ends the count early (hour units stop at 3 after 2x).
module bcd_digit_ctr
  import bcd_time_pkg::*;
#(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_i,
  input  logic       wrap_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] q_o,
  output logic [3:0] nxt_o,
  output logic       carry_o
);

  logic [3:0] r_q;
  logic [3:0] w_nxt;
  logic       w_at_max;

  // Next digit value: load wins, otherwise increment with wrap at terminal count.
  always_comb begin
    w_at_max = (r_q == MAX) | wrap_i;
    w_nxt    = r_q;
    if (load_i) begin
      w_nxt = load_val_i;
    end else if (en_i) begin
      if (w_at_max) w_nxt = DIGIT_ZERO;
      else          w_nxt = r_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_q <= DIGIT_ZERO;
    else          r_q <= w_nxt;
  end

  assign q_o     = r_q;
  assign nxt_o   = w_nxt;
  assign carry_o = en_i & w_at_max;

endmodule

// File: rtl/bcd_time_of_day.sv
// BCD time-of-day counter HH:MM[:SS] advanced by a single-cycle tick enable,
// with validated load, hh:mm alarm, day-wrap pulse and 12h display conversion.
module bcd_time_of_day
  import bcd_time_pkg::*;
#(
  parameter bit SEC_EN   = 1'b1,
  parameter bit ALARM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_i,
  input  logic       mode_12h_i,
  input  logic       load_i,
  input  logic [7:0] load_hour_i,
  input  logic [7:0] load_min_i,
  input  logic [7:0] load_sec_i,
  input  logic       alarm_en_i,
  input  logic [7:0] alarm_hour_i,
  input  logic [7:0] alarm_min_i,
  output logic [7:0] hour_o,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       pm_o,
  output logic       day_wrap_o,
  output logic       alarm_hit_o,
  output logic       load_err_o
);

  logic       w_load_valid;
  logic       w_sec_ok;
  logic       w_load_ok;
  logic       w_load_bad;
  logic       w_tick;
  logic [7:0] w_ld_sec;
  logic       w_su_en, w_mu_en;
  logic       w_su_c, w_st_c, w_mu_c, w_mt_c, w_hu_c, w_ht_c;
  logic       w_hu_wrap;
  bcd_time_t  w_now;
  bcd_time_t  w_nxt;
  logic       w_alarm_match;
  logic [8:0] w_h12;
  logic       r_day_wrap;
  logic       r_alarm_hit;
  logic       r_load_err;

  assign w_sec_ok     = !SEC_EN || bcd_valid(load_sec_i, MINSEC_MAX);
  assign w_load_valid = bcd_valid(load_hour_i, HOUR_MAX) &&
                        bcd_valid(load_min_i, MINSEC_MAX) && w_sec_ok;
  assign w_load_ok    = load_i & w_load_valid;
  assign w_load_bad   = load_i & ~w_load_valid;
  // Any load request, accepted or not, swallows a coincident tick.
  assign w_tick       = tick_i & ~load_i;
  assign w_ld_sec     = SEC_EN ? load_sec_i : TIME_RESET;

  assign w_su_en   = w_tick & SEC_EN;
  assign w_mu_en   = SEC_EN ? w_st_c : w_tick;
  assign w_hu_wrap = (w_now.hour[7:4] == HOUR_TENS_MAX) && (w_now.hour[3:0] == HOUR_UNITS_WRAP);

  bcd_digit_ctr #(.MAX(BCD_UNITS_MAX)) u_sec_u (
    .clk(clk), .reset_n(reset_n), .en_i(w_su_en), .wrap_i(1'b0),
    .load_i(w_load_ok), .load_val_i(w_ld_sec[3:0]),
    .q_o(w_now.sec[3:0]), .nxt_o(w_nxt.sec[3:0]), .carry_o(w_su_c)
  );

  bcd_digit_ctr #(.MAX(BCD_TENS_MAX)) u_sec_t (
    .clk(clk), .reset_n(reset_n), .en_i(w_su_c), .wrap_i(1'b0),
    .load_i(w_load_ok), .load_val_i(w_ld_sec[7:4]),
    .q_o(w_now.sec[7:4]), .nxt_o(w_nxt.sec[7:4]), .carry_o(w_st_c)
  );

  bcd_digit_ctr #(.MAX(BCD_UNITS_MAX)) u_min_u (
    .clk(clk), .reset_n(reset_n), .en_i(w_mu_en), .wrap_i(1'b0),
    .load_i(w_load_ok), .load_val_i(load_min_i[3:0]),
    .q_o(w_now.min[3:0]), .nxt_o(w_nxt.min[3:0]), .carry_o(w_mu_c)
  );

  bcd_digit_ctr #(.MAX(BCD_TENS_MAX)) u_min_t (
    .clk(clk), .reset_n(reset_n), .en_i(w_mu_c), .wrap_i(1'b0),
    .load_i(w_load_ok), .load_val_i(load_min_i[7:4]),
    .q_o(w_now.min[7:4]), .nxt_o(w_nxt.min[7:4]), .carry_o(w_mt_c)
  );

  // Hour units end at 3 when tens is 2; its carry then wraps tens 2 -> 0.
  bcd_digit_ctr #(.MAX(BCD_UNITS_MAX)) u_hour_u (
    .clk(clk), .reset_n(reset_n), .en_i(w_mt_c), .wrap_i(w_hu_wrap),
    .load_i(w_load_ok), .load_val_i(load_hour_i[3:0]),
    .q_o(w_now.hour[3:0]), .nxt_o(w_nxt.hour[3:0]), .carry_o(w_hu_c)
  );

  // Tens carry only occurs on 23:59[:59] -> 00:00[:00], so it is the day wrap.
  bcd_digit_ctr #(.MAX(HOUR_TENS_MAX)) u_hour_t (
    .clk(clk), .reset_n(reset_n), .en_i(w_hu_c), .wrap_i(1'b0),
    .load_i(w_load_ok), .load_val_i(load_hour_i[7:4]),
    .q_o(w_now.hour[7:4]), .nxt_o(w_nxt.hour[7:4]), .carry_o(w_ht_c)
  );

  assign w_alarm_match = ALARM_EN && alarm_en_i && w_tick &&
                         (w_nxt.hour == alarm_hour_i) &&
                         (w_nxt.min == alarm_min_i) &&
                         (w_nxt.sec == TIME_RESET);

  // Event pulses, high for the one cycle after the causing edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_day_wrap  <= 1'b0;
      r_alarm_hit <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_day_wrap  <= w_ht_c;
      r_alarm_hit <= w_alarm_match;
      r_load_err  <= w_load_bad;
    end
  end

  assign w_h12       = h24_to_h12(w_now.hour);
  assign hour_o      = mode_12h_i ? w_h12[7:0] : w_now.hour;
  assign pm_o        = mode_12h_i & w_h12[8];
  assign min_o       = w_now.min;
  assign sec_o       = w_now.sec;
  assign day_wrap_o  = r_day_wrap;
  assign alarm_hit_o = r_alarm_hit;
  assign load_err_o  = r_load_err;

endmodule
